// File: rtl/polymul_negacyclic_if.sv
// Valid/ready stream bundle with an end-of-frame marker.
// The master drives vld/data/last and the slave drives rdy.
interface axis_if #(
   parameter int W = 8
) ();
   logic         vld;
   logic         rdy;
   logic [W-1:0] data;
   logic         last;

   modport master (output vld, output data, output last, input rdy);
   modport slave  (input vld, input data, input last, output rdy);
endinterface

// File: rtl/polymul_negacyclic.sv
// Negacyclic polynomial multiplier: z = a*b mod (x^N + 1), coefficients mod Q.
// Frame flow: LOAD (N joint p/u beats) -> COMPUTE (N MAC cycles, one
// u coefficient per cycle applied to all N accumulators) -> DRAIN (N
// registered output beats with backpressure).
module polymul_negacyclic #(
   parameter int N        = 4,
   parameter int QW       = 5,
   parameter int Q        = 32,
   parameter int UW       = 2,
   parameter int U_SIGNED = 1
) (
   input  logic   clk,
   input  logic   s_rst,
   axis_if.slave  p,
   axis_if.slave  u,
   axis_if.master z,
   output logic   err,
   output logic   busy
);
   localparam int CW = $clog2(N);
   // Room for acc + (2^QW-1)*2^UW in either sign with margin.
   localparam int AW = QW + UW + 4;
   localparam logic signed [AW-1:0] Q_S = AW'(Q);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            rdy_q, rdy_d;
   logic            err_q, err_d;
   logic            z_vld_q, z_vld_d;
   logic            z_last_q, z_last_d;
   logic [QW-1:0]   z_data_q, z_data_d;

   logic [QW-1:0]   p_buf_q [N];
   logic [QW-1:0]   p_buf_d [N];
   logic [UW-1:0]   u_buf_q [N];
   logic [UW-1:0]   u_buf_d [N];
   logic [QW-1:0]   acc_q   [N];
   logic [QW-1:0]   acc_d   [N];
   logic [QW-1:0]   acc_red [N];

   logic            accept;
   logic            cnt_last;
   logic [CW-1:0]   cnt_nxt;
   logic [UW-1:0]   u_sel;
   logic signed [AW-1:0] u_ext;

   // rdy is only ever high in LOAD, so this also implies the state
   assign accept   = rdy_q & p.vld & u.vld;
   assign cnt_last = (cnt_q == CNT_LAST);
   assign cnt_nxt  = cnt_q + CW'(1);

   assign p.rdy  = rdy_q;
   assign u.rdy  = rdy_q;
   assign z.vld  = z_vld_q;
   assign z.last = z_last_q;
   assign z.data = z_data_q;
   assign err    = err_q;
   assign busy   = !((state_q == LOAD) && (cnt_q == '0));

   // Select u_j for the current compute cycle and widen it
   always_comb begin
      u_sel = u_buf_q[cnt_q];
      if (U_SIGNED != 0) begin
         u_ext = AW'($signed(u_sel));
      end else begin
         u_ext = $signed(AW'(u_sel));
      end
   end

   // One MAC lane per output coefficient k; wrapped terms (k < j) are subtracted
   for (genvar gi = 0; gi < N; gi++) begin : g_mac
      logic [CW-1:0]        idx;
      logic signed [AW-1:0] p_ext;
      logic signed [AW-1:0] prod;
      logic signed [AW-1:0] base;
      logic signed [AW-1:0] sum;
      logic signed [AW-1:0] red;

      // acc_k + s*u_j*p_((k-j) mod N), reduced into [0, Q-1]
      always_comb begin
         if (int'(cnt_q) > gi) begin
            idx = CW'(gi + N - int'(cnt_q));
         end else begin
            idx = CW'(gi - int'(cnt_q));
         end
         p_ext = $signed(AW'(p_buf_q[idx]));
         prod  = p_ext * u_ext;
         base  = (cnt_q == '0) ? '0 : $signed(AW'(acc_q[gi]));
         sum   = (int'(cnt_q) > gi) ? (base - prod) : (base + prod);
         red   = sum % Q_S;
         if (red < 0) begin
            red = red + Q_S;
         end
      end

      assign acc_red[gi] = red[QW-1:0];
   end

   // Buffer writes on accepted beats; accumulators update only in COMPUTE
   always_comb begin
      for (int k = 0; k < N; k++) begin
         p_buf_d[k] = p_buf_q[k];
         u_buf_d[k] = u_buf_q[k];
         acc_d[k]   = acc_q[k];
      end
      if (accept) begin
         p_buf_d[cnt_q] = p.data;
         u_buf_d[cnt_q] = u.data;
      end
      if (state_q == COMPUTE) begin
         for (int k = 0; k < N; k++) begin
            acc_d[k] = acc_red[k];
         end
      end
   end

   // Next-state, counter, framing check and output register logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      z_vld_d  = z_vld_q;
      z_last_d = z_last_q;
      z_data_d = z_data_q;
      case (state_q)
         LOAD: begin
            if (accept) begin
               if (cnt_last ? !(p.last && u.last) : (p.last || u.last)) begin
                  err_d = 1'b1;
               end
               if (cnt_last) begin
                  state_d = COMPUTE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_nxt;
               end
            end
         end
         COMPUTE: begin
            if (cnt_last) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_nxt;
            end
         end
         DRAIN: begin
            if (!z_vld_q) begin
               // first DRAIN cycle: register z_0 from the settled accumulators
               z_vld_d  = 1'b1;
               z_last_d = 1'b0;
               z_data_d = acc_q[0];
            end else if (z.rdy) begin
               if (cnt_last) begin
                  state_d  = LOAD;
                  cnt_d    = '0;
                  z_vld_d  = 1'b0;
                  z_last_d = 1'b0;
                  z_data_d = '0;
               end else begin
                  cnt_d    = cnt_nxt;
                  z_data_d = acc_q[cnt_nxt];
                  z_last_d = (cnt_q == CW'(N - 2));
               end
            end
         end
         default: begin
            state_d = LOAD;
            cnt_d   = '0;
         end
      endcase
      rdy_d = (state_d == LOAD);
   end

   // Control and output registers; reset lands in LOAD with rdy still low
   always_ff @(posedge clk or posedge s_rst) begin
      if (s_rst) begin
         state_q  <= LOAD;
         cnt_q    <= '0;
         rdy_q    <= 1'b0;
         err_q    <= 1'b0;
         z_vld_q  <= 1'b0;
         z_last_q <= 1'b0;
         z_data_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rdy_q    <= rdy_d;
         err_q    <= err_d;
         z_vld_q  <= z_vld_d;
         z_last_q <= z_last_d;
         z_data_q <= z_data_d;
      end
   end

   // Coefficient buffers and accumulators
   always_ff @(posedge clk or posedge s_rst) begin
      if (s_rst) begin
         for (int k = 0; k < N; k++) begin
            p_buf_q[k] <= '0;
            u_buf_q[k] <= '0;
            acc_q[k]   <= '0;
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            p_buf_q[k] <= p_buf_d[k];
            u_buf_q[k] <= u_buf_d[k];
            acc_q[k]   <= acc_d[k];
         end
      end
   end
endmodule

// File: tb/tb_polymul_negacyclic.sv
// Directed bench for polymul_negacyclic (N=4, Q=32, QW=5, UW=2, signed u).
module tb_polymul_negacyclic;
   localparam int N  = 4;
   localparam int QW = 5;
   localparam int Q  = 32;
   localparam int UW = 2;

   logic clk   = 1'b0;
   logic s_rst = 1'b0;
   logic err;
   logic busy;

   always #5 clk = ~clk;

   axis_if #(QW) p_if ();
   axis_if #(UW) u_if ();
   axis_if #(QW) z_if ();

   polymul_negacyclic #(.N(N), .QW(QW), .Q(Q), .UW(UW), .U_SIGNED(1)) dut (
      .clk   (clk),
      .s_rst (s_rst),
      .p     (p_if),
      .u     (u_if),
      .z     (z_if),
      .err   (err),
      .busy  (busy)
   );

   typedef struct packed {
      logic [3:0][4:0] p;
      logic [3:0][1:0] u;
      logic [3:0][4:0] z;
      logic [3:0]      pat;    // z.rdy pattern, bit 0 first, repeating
      logic            bad;    // last on beat 1 instead of beat 3
      logic [3:0]      stall;  // cycles of lone p.vld before beat 0
   } vec_t;

   int  checks = 0;
   int  errors = 0;
   time t_first;
   time t_last;

   function automatic vec_t mk(input int p0, p1, p2, p3, u0, u1, u2, u3,
                               z0, z1, z2, z3, input logic [3:0] pat,
                               input logic bad, input int stall);
      vec_t v;
      v.p[0] = 5'(p0); v.p[1] = 5'(p1); v.p[2] = 5'(p2); v.p[3] = 5'(p3);
      v.u[0] = 2'(u0); v.u[1] = 2'(u1); v.u[2] = 2'(u2); v.u[3] = 2'(u3);
      v.z[0] = 5'(z0); v.z[1] = 5'(z1); v.z[2] = 5'(z2); v.z[3] = 5'(z3);
      v.pat   = pat;
      v.bad   = bad;
      v.stall = 4'(stall);
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic reset_vals(input string tag);
      chk({tag, "_p_rdy"}, int'(p_if.rdy), 0);
      chk({tag, "_u_rdy"}, int'(u_if.rdy), 0);
      chk({tag, "_z_vld"}, int'(z_if.vld), 0);
      chk({tag, "_z_last"}, int'(z_if.last), 0);
      chk({tag, "_z_data"}, int'(z_if.data), 0);
      chk({tag, "_err"}, int'(err), 0);
      chk({tag, "_busy"}, int'(busy), 0);
   endtask

   // One joint p/u beat; called and returns at a negedge.
   task automatic beat(input logic [4:0] pd, input logic [1:0] ud, input logic lst, input int stall);
      int to;
      p_if.data = pd;  u_if.data = ud;
      p_if.last = lst; u_if.last = lst;
      p_if.vld  = 1'b1;
      u_if.vld  = (stall == 0);
      if (stall > 0) begin
         repeat (stall) @(negedge clk);
         chk("stall_busy", int'(busy), 0);
         chk("stall_rdy", int'(p_if.rdy), 1);
         u_if.vld = 1'b1;
      end
      to = 0;
      while (!p_if.rdy && to < 50) begin
         @(negedge clk);
         to++;
      end
      if (!p_if.rdy) chk("beat_timeout", 0, 1);
      @(posedge clk);
      t_last = $time;
      @(negedge clk);
      p_if.vld = 1'b0; u_if.vld = 1'b0;
      p_if.last = 1'b0; u_if.last = 1'b0;
   endtask

   task automatic send(input vec_t v);
      for (int b = 0; b < N; b++) begin
         beat(v.p[b], v.u[b], v.bad ? (b == 1) : (b == N - 1), (b == 0) ? int'(v.stall) : 0);
         if (b == 0) t_first = t_last;
      end
   endtask

   // Collect N outputs under the vector's rdy pattern; starts at the negedge
   // right after the final input edge.
   task automatic receive(input vec_t v, input bit chk_lat, input string tag);
      int lat = 0, got = 0, k = 0, to = 0;
      bit seen = 0, held = 0;
      logic [4:0] hd = '0;
      logic       hl = 1'b0;
      while (got < N && to < 100) begin
         z_if.rdy = v.pat[k % 4];
         k++;
         if (z_if.vld) begin
            if (!seen && chk_lat) chk("latency", lat, N + 1);
            seen = 1;
            chk("drain_p_rdy", int'(p_if.rdy), 0);
            if (held) begin
               chk("hold_data", int'(z_if.data), int'(hd));
               chk("hold_last", int'(z_if.last), int'(hl));
            end
            if (z_if.rdy) begin
               $display("%s z[%0d]=%0d last=%0d err=%0d", tag, got, z_if.data, z_if.last, err);
               chk({tag, "_data"}, int'(z_if.data), int'(v.z[got]));
               chk({tag, "_last"}, int'(z_if.last), (got == N - 1) ? 1 : 0);
               got++;
               held = 0;
            end else begin
               held = 1;
               hd = z_if.data;
               hl = z_if.last;
            end
         end else if (!seen) begin
            lat++;
         end else begin
            chk("vld_dropped", 0, 1);
         end
         @(negedge clk);
         to++;
      end
      if (got < N) chk("drain_timeout", got, N);
      z_if.rdy = 1'b1;
      chk({tag, "_idle_vld"}, int'(z_if.vld), 0);
      chk({tag, "_idle_busy"}, int'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1);
   end

   initial begin
      vec_t tbl [4];
      vec_t va, vb, vbad;
      time  tla;
      int   to;

      tbl[0] = mk(30, 8, 31, 4,  1, 1, 1, 1,  19, 3, 1, 9,    4'b1111, 1'b0, 0);
      tbl[1] = mk(3, 4, 5, 6,    1, 0, 1, 1,  26, 25, 2, 13,  4'b0101, 1'b0, 0);
      tbl[2] = mk(30, 8, 31, 4,  1, 1, 1, 1,  19, 3, 1, 9,    4'b1111, 1'b0, 3);
      tbl[3] = mk(31, 31, 31, 31, -2, -2, -2, -2, 28, 0, 4, 8, 4'b1011, 1'b0, 0);
      va     = mk(1, 2, 3, 4,    -1, 0, 0, 0, 31, 30, 29, 28, 4'b1111, 1'b0, 0);
      vb     = mk(1, 2, 3, 4,    0, 1, 0, 0,  28, 1, 2, 3,    4'b1111, 1'b0, 0);
      vbad   = mk(3, 4, 5, 6,    1, 0, 1, 1,  26, 25, 2, 13,  4'b1111, 1'b1, 0);

      p_if.vld = 1'b0; p_if.data = '0; p_if.last = 1'b0;
      u_if.vld = 1'b0; u_if.data = '0; u_if.last = 1'b0;
      z_if.rdy = 1'b1;

      // power-up reset
      #1 s_rst = 1'b1;
      #1 reset_vals("por");
      repeat (2) @(negedge clk);
      s_rst = 1'b0;
      #1 chk("rdy_before_edge", int'(p_if.rdy), 0);
      @(negedge clk);
      chk("rdy_after_release", int'(p_if.rdy), 1);
      chk("idle_z_vld", int'(z_if.vld), 0);

      // table-driven frames
      for (int i = 0; i < 4; i++) begin
         send(tbl[i]);
         receive(tbl[i], 1'b1, $sformatf("vec%0d", i));
         chk("err_clean", int'(err), 0);
      end

      // back-to-back frames: next frame's first beat 2N+2 cycles after last beat
      send(va);
      tla = t_last;
      fork
         receive(va, 1'b1, "b2b_a");
         send(vb);
      join
      chk("b2b_period", int'((t_first - tla) / 10), 2 * N + 2);
      receive(vb, 1'b0, "b2b_b");

      // early last: err sets, frame still 4 beats with correct result, sticky
      send(vbad);
      receive(vbad, 1'b1, "badlast");
      chk("err_set", int'(err), 1);
      send(tbl[0]);
      receive(tbl[0], 1'b1, "after_err");
      chk("err_sticky", int'(err), 1);

      // reset after two input beats
      beat(5'd7, 2'd1, 1'b0, 0);
      beat(5'd9, 2'd1, 1'b0, 0);
      #2 s_rst = 1'b1;
      #1 reset_vals("rst_load");
      @(negedge clk);
      s_rst = 1'b0;
      @(negedge clk);
      chk("rst_load_rdy", int'(p_if.rdy), 1);
      send(tbl[0]);
      receive(tbl[0], 1'b1, "post_rst_load");
      chk("post_rst_err", int'(err), 0);

      // reset while DRAIN holds z_0 under backpressure
      send(tbl[0]);
      z_if.rdy = 1'b0;
      to = 0;
      while (!z_if.vld && to < 50) begin
         @(negedge clk);
         to++;
      end
      chk("drain_reached", int'(z_if.vld), 1);
      chk("drain_hold_z0", int'(z_if.data), 19);
      #2 s_rst = 1'b1;
      #1 reset_vals("rst_drain");
      @(negedge clk);
      s_rst = 1'b0;
      z_if.rdy = 1'b1;
      @(negedge clk);
      chk("rst_drain_rdy", int'(p_if.rdy), 1);
      send(tbl[1]);
      receive(tbl[1], 1'b1, "post_rst_drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/polymul_negacyclic.md
POLYMUL_NEGACYCLIC -- requirements
Module: polymul_negacyclic

Interface
REQ-001 SHALL have parameter N, default 4: coefficients per polynomial frame, N >= 2.
REQ-002 SHALL have parameter QW, default 5: modulus and p/z coefficient width.
REQ-003 SHALL have parameter Q, default 32: modulus, 2 <= Q <= 2^QW.
REQ-004 SHALL have parameter UW, default 2: u coefficient width, 1..3.
REQ-005 SHALL have parameter U_SIGNED, default 1: 1 = u is two's complement, 0 = u is unsigned.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-007 SHALL have port s_rst, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port p, axis_if #(QW) slave (vld, rdy, data, last): polynomial a coefficients, index 0 first.
REQ-009 SHALL have port u, axis_if #(UW) slave (vld, rdy, data, last): polynomial b coefficients, index 0 first.
REQ-010 SHALL have port z, axis_if #(QW) master (vld, rdy, data, last): product coefficients, index 0 first.
REQ-011 SHALL have port err, output, 1: sticky framing-error flag.
REQ-012 SHALL have port busy, output, 1: high in any state other than LOAD with beat count 0.

Function
REQ-013 SHALL compute z_k = (sum over i+j=k of p_i*u_j - sum over i+j=k+N of p_i*u_j) mod Q, for k = 0..N-1, with each z_k in [0, Q-1].
REQ-014 SHALL use FSM states LOAD -> COMPUTE -> DRAIN -> LOAD.
REQ-015 LOAD SHALL drive p.rdy = u.rdy = 1; all other states SHALL drive both to 0.
REQ-016 A beat SHALL be accepted only on an edge where p.vld && u.vld && rdy; a lone p.vld or lone u.vld SHALL be stalled, with nothing consumed.
REQ-017 LOAD SHALL store accepted beats into N-entry p and u buffers and count 0..N-1.
REQ-018 Frame length SHALL be fixed by the count: the beat at count N-1 ends LOAD regardless of the last inputs.
REQ-019 err SHALL be set, and held until reset, when either last is high at count != N-1, or either last is low at count N-1.
REQ-020 COMPUTE SHALL last exactly N cycles.
REQ-021 COMPUTE cycle j SHALL clear the accumulators at j = 0, then apply acc_k = (acc_k + s*u_j*p_((k-j) mod N)) mod Q for all k in parallel, with s = -1 when k < j and s = +1 otherwise.
REQ-022 u SHALL be sign-extended when U_SIGNED = 1; intermediate widths SHALL be sufficient that no overflow precedes the reduction.
REQ-023 DRAIN SHALL present z_0..z_N-1 in order, with z.last high only on z_N-1.
REQ-024 z.data, z.last and z.vld SHALL hold stable while z.vld && !z.rdy, and SHALL advance only on z.vld && z.rdy.
REQ-025 Latency: if the final input beat is accepted at edge E and z.rdy = 1, z_0 SHALL be valid after edge E+N+1, then one coefficient per cycle.
REQ-026 Minimum frame period SHALL be 2N+2 cycles.
REQ-027 After z_N-1 is accepted, the FSM SHALL return to LOAD on the next edge; input buffers MAY be overwritten only in LOAD.
REQ-028 z.vld SHALL be 0 in LOAD and COMPUTE.
REQ-029 err SHALL NOT alter the datapath; frames with err set SHALL still produce the REQ-013 result.

Reset
REQ-030 Asserting s_rst SHALL immediately force state = LOAD, count = 0, p.rdy = u.rdy = 0, z.vld = 0, z.last = 0, z.data = 0, err = 0 and busy = 0, in any state and mid-frame.
REQ-031 p.rdy and u.rdy SHALL rise on the first edge after s_rst deasserts; partial frames in flight SHALL be discarded.

Verification (N=4, Q=32, QW=5, UW=2, U_SIGNED=1)
REQ-032 Input p={30,8,31,4}, u={1,1,1,1}, last on beat 3, z.rdy=1 -> z={19,3,1,9}, z.last on the 4th output beat, err=0, first z.vld after edge E+5.
REQ-033 Input p={3,4,5,6}, u={1,0,1,1}, with z.rdy toggling 1,0,1,0 -> z={26,25,2,13}; each value held while rdy is 0; no input accepted until drain completes.
REQ-034 Signed and rotation cases: input p={1,2,3,4}, u={-1,0,0,0} -> z={31,30,29,28}; then input p={1,2,3,4}, u={0,1,0,0} -> z={28,1,2,3}, back-to-back with a period of 10 cycles.
REQ-035 p.vld=1 with u.vld held 0 for 3 cycles, then both high -> no beat counted during the stall; the result is identical to the unstalled case.
REQ-036 Last on beat 1 of a 4-beat frame -> err=1 sticky; the frame is still 4 beats and the correct z is produced.
REQ-037 s_rst asserted after 2 input beats, and separately mid-DRAIN -> all outputs reach reset values asynchronously; the next full frame gives the correct result.
